uart_tx_arbiter: RTL

Shares the single serial TX port (tx_data / new_tx_data / tx_busy into the AVR interface) among NUM_REQ message-printer style requesters. Round-robin grant, held for a whole message: the winner owns the port until it drops its request or goes silent past a timeout. Sits between the printer/debug blocks and the AVR interface; each requester sees a port identical to a private one, except that busy is forced high while it is not granted.

---
 rtl/uart_tx_arbiter_pkg.sv | 10 +
 rtl/uart_tx_arbiter_rr_picker.sv | 28 ++
 rtl/uart_tx_arbiter.sv | 76 +++++++
 3 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg: FSM state encoding and clog2 helper for the TX arbiter
package uart_tx_arbiter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, OWN = 2'd1, RELEASE = 2'd2} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int n = v - 1; n > 0; n = n >> 1) r++;
    return r;
  endfunction
endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// rr_picker: combinational round-robin pick; eligible/last in, one-hot pick, index and found out
module rr_picker
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N = 4,
  parameter int IW = clog2(N)
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  pick,
  output logic [IW-1:0] idx,
  output logic          found
);
  logic [IW-1:0] c;
  always_comb begin
    idx = '0;
    found = 1'b0;
    c = '0;
    for (int k = N; k >= 1; k--) begin
      c = IW'((int'(last) + k) % N);
      if (eligible[c]) begin
        idx = c;
        found = 1'b1;
      end
    end
  end
  assign pick = found ? N'(1) << idx : '0;
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, message-held sharing of one UART TX port; req/new_data/data/busy per requester, grant/revoked status, tx_data/new_tx_data/tx_busy to the AVR interface
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   new_data,
  input  logic [8*NUM_REQ-1:0] data,
  output logic [NUM_REQ-1:0]   busy,
  output logic [NUM_REQ-1:0]   grant,
  output logic [7:0]           tx_data,
  output logic                 new_tx_data,
  input  logic                 tx_busy,
  output logic                 revoked
);
  localparam int IW = clog2(NUM_REQ);
  localparam int TW = TIMEOUT == 0 ? 1 : clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);
  state_t state, state_nx;
  logic [IW-1:0] owner, last, pick_idx;
  logic [NUM_REQ-1:0] lockout, eligible, pick;
  logic [TW-1:0] timer;
  logic found, own, owner_req, fwd, timed_out, revoke;
  assign own = state == OWN;
  assign eligible = req & ~lockout;
  assign owner_req = req[owner];
  assign fwd = own & new_data[owner] & ~tx_busy;
  assign timed_out = (TIMEOUT != 0) && (timer == TMAX);
  assign revoke = own & owner_req & timed_out;
  rr_picker #(.N(NUM_REQ), .IW(IW)) u_pick (
    .eligible (eligible),
    .last     (last),
    .pick     (pick),
    .idx      (pick_idx),
    .found    (found)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      owner <= '0;
      last <= IW'(NUM_REQ - 1);
      timer <= '0;
      lockout <= '0;
      revoked <= 1'b0;
    end else begin
      state <= state_nx;
      revoked <= revoke;
      lockout <= (lockout & req) | (revoke ? NUM_REQ'(1) << owner : '0);
      if (state == IDLE && found) begin
        grant <= pick;
        owner <= pick_idx;
        last <= pick_idx;
        timer <= '0;
      end else if (own) begin
        grant <= state_nx == OWN ? grant : '0;
        timer <= (fwd || tx_busy) ? '0 : (timer == TMAX ? timer : timer + 1'b1);
      end
    end
  end
  always_comb begin
    state_nx = state == IDLE ? (found ? OWN : IDLE)
             : state == OWN  ? ((!owner_req || timed_out) ? RELEASE : OWN)
             : IDLE;
  end
  always_comb begin
    busy = '1;
    busy[owner] = own ? tx_busy : 1'b1;
    tx_data = own ? data[{owner, 3'b000} +: 8] : 8'h00;
    new_tx_data = fwd;
  end
endmodule
